// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth and the
// launch-sequencer state encodings.
package uart_tx_fifo_pkg;

    // Default log2 of the FIFO depth (16 entries).
    localparam int DEPTH_LOG2_DEFAULT = 4;

    // Launch sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the UART transmit FIFO: one synchronous write port and
// one asynchronous read port, so the head byte is visible in the same cycle
// the launch sequencer decides to pop it.
module sync_fifo_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    // Write the incoming byte into the addressed slot.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer placed in front of a UART transmitter.
// Bytes are accepted at clock rate; one byte per frame is launched with a
// single-cycle TxD_start pulse, with TxD_busy acting as back-pressure.
// Optional feature: define UART_TX_FIFO_LEVEL_EN to expose the occupancy
// on the level output.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       TxD_start,
    output logic [7:0] TxD_data,
    input  logic       TxD_busy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_ZERO  = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);

    tx_state_e             state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q;
    logic                  overflow_q, overflow_d;
    logic                  start_q, start_d;
    logic [7:0]            data_q, data_d;
    logic                  wr_accept_s;
    logic                  pop_s;
    logic [7:0]            rd_data_s;

    sync_fifo_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (8)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_accept_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data_s)
    );

    // State register for the launch sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: launch once, then wait out the transmitter's busy period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (TxD_busy) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: decide the pop and stage the launch pulse and byte.
    always_comb begin
        pop_s   = 1'b0;
        start_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !TxD_busy) begin
                    pop_s   = 1'b1;
                    start_d = 1'b1;
                    data_d  = rd_data_s;
                end else begin
                    pop_s   = 1'b0;
                    start_d = 1'b0;
                    data_d  = data_q;
                end
            end
            ST_LAUNCH: start_d = 1'b0;
            ST_WAIT:   start_d = 1'b0;
            default:   start_d = 1'b0;
        endcase
    end

    // Pointer, occupancy and overflow bookkeeping; full is judged pre-edge,
    // so a write while full is dropped even if a pop happens the same cycle.
    always_comb begin
        wr_accept_s = wr_en && !full_q;
        overflow_d  = overflow_q || (wr_en && full_q);
        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Datapath registers; flags are registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_CNT);
            empty_q    <= (count_d == CNT_ZERO);
            overflow_q <= overflow_d;
            start_q    <= start_d;
            data_q     <= data_d;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = overflow_q;
    assign TxD_start = start_q;
    assign TxD_data  = data_q;

`ifdef UART_TX_FIFO_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a transmitter model raises busy the
// cycle after TxD_start and holds it for 20 cycles; launched bytes are
// compared against a queue of expected bytes by an independent monitor.
module tb_uart_tx_fifo;

    localparam int BUSY_N = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       full, empty, overflow, TxD_start, TxD_busy;
    logic [7:0] TxD_data;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;
    logic       prev_start = 1'b0;
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    uart_tx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .TxD_start (TxD_start),
        .TxD_data  (TxD_data),
        .TxD_busy  (TxD_busy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for BUSY_N cycles after seeing TxD_start; not reset by rst.
    always @(posedge clk) begin
        if (TxD_start) busy_cnt <= BUSY_N;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign TxD_busy = (busy_cnt != 0) || hold_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every launch pulse must match the next expected byte.
    always @(negedge clk) begin
        if (TxD_start) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_launch: data %0h with no byte expected", TxD_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (TxD_data !== e) begin
                    errors++;
                    $display("FAIL launch_data: got %0h expected %0h", TxD_data, e);
                end
            end
            chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
            chk("start_while_busy", {31'd0, TxD_busy}, 32'd0);
        end
        prev_start = TxD_start;
    end

    // Caller sits at a negedge; the byte is sampled at the following posedge.
    task automatic wr(input logic [7:0] b, input bit expect_kept);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_kept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && !TxD_busy && empty) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, (exp_q.size() == 0 && !TxD_busy && empty)}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // 1. Reset and idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_data", {24'd0, TxD_data}, 32'h00);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rst_level", {27'd0, level}, 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            chk("idle_no_start", {31'd0, TxD_start}, 32'd0);
            @(negedge clk);
        end

        // 2. Single byte: launch pulse in the cycle after the edge following the write.
        wr(8'hA5, 1'b1);
        chk("lat_not_yet", {31'd0, TxD_start}, 32'd0);
        @(negedge clk);
        chk("lat_start", {31'd0, TxD_start}, 32'd1);
        chk("lat_data", {24'd0, TxD_data}, 32'hA5);
        @(negedge clk);
        chk("lat_pulse_end", {31'd0, TxD_start}, 32'd0);
        drain("drain_single", 100);
        chk("single_empty", {31'd0, empty}, 32'd1);

        // 3. Burst of 16 with an idle transmitter: a pop occurs, so never full.
        for (int i = 0; i < 16; i++) wr(8'(i), 1'b1);
        chk("burst_not_full", {31'd0, full}, 32'd0);
        drain("drain_burst", 16 * 40);

        // 4. 17 writes while busy is held; the 17th coincides with a pop and is dropped.
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b1);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("ovf_level", {27'd0, level}, 32'd16);
`endif
        hold_busy = 1'b0;
        wr(8'hEE, 1'b0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("ovf_after_pop", {31'd0, full}, 32'd0);
        drain("drain_ovf", 16 * 40);
        chk("ovf_still_set", {31'd0, overflow}, 32'd1);

        // 5. Count at DEPTH-1, then write and pop together: count must stay at 15.
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) wr(8'h90 + 8'(i), 1'b1);
        chk("cnt15_not_full", {31'd0, full}, 32'd0);
        hold_busy = 1'b0;
        wr(8'h80, 1'b1);
        chk("cnt_same_not_full", {31'd0, full}, 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("cnt_same_level", {27'd0, level}, 32'd15);
`endif
        wr(8'h81, 1'b1);
        chk("cnt16_full", {31'd0, full}, 32'd1);
        drain("drain_cnt", 17 * 40);

        // 5b. 40 spaced bytes so the pointers wrap repeatedly.
        for (int i = 0; i < 40; i++) begin
            wr(8'(i * 7 + 3), 1'b1);
            repeat (24) @(negedge clk);
        end
        drain("drain_wrap", 40 * 40);

        // 6. Reset while the sequencer waits out a frame with 5 bytes queued.
        wr(8'h55, 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1'b0);
        chk("pre_rst_busy", {31'd0, TxD_busy}, 32'd1);
        chk("pre_rst_queued", {31'd0, empty}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_start", {31'd0, TxD_start}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_full", {31'd0, full}, 32'd0);
        begin
            int n = 0;
            while (TxD_busy && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("busy_falls", {31'd0, TxD_busy}, 32'd0);
        end
        wr(8'h3C, 1'b1);
        drain("drain_after_rst", 100);
        chk("queue_empty_end", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
